// File: rtl/mul_div_unit.sv
// ============================================================================
// Module  : mul_div_unit
// Purpose : Iterative shift-add multiplier / restoring divider with HI/LO regs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] out
);

    localparam logic [5:0] c_MFHI  = 6'h10;
    localparam logic [5:0] c_MTHI  = 6'h11;
    localparam logic [5:0] c_MFLO  = 6'h12;
    localparam logic [5:0] c_MTLO  = 6'h13;
    localparam logic [5:0] c_MULT  = 6'h18;
    localparam logic [5:0] c_MULTU = 6'h19;
    localparam logic [5:0] c_DIV   = 6'h1A;
    localparam logic [5:0] c_DIVU  = 6'h1B;

    localparam int            CW         = $clog2(WIDTH);
    localparam logic [CW-1:0] c_CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   opa_q;     // multiplier / dividend-then-quotient shift register
    logic [WIDTH-1:0]   opb_q;     // multiplicand / divisor
    logic [2*WIDTH-1:0] acc_q;     // product accumulator; low half holds the remainder
    logic               neg_q;     // product or quotient sign
    logic               rneg_q;
    logic               dz_q;
    logic               is_div_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               is_signed;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH:0]     mul_sum_d;
    logic [2*WIDTH-1:0] mul_acc_d;
    logic [WIDTH:0]     div_shift_d;
    logic [WIDTH+1:0]   div_diff_d;
    logic               div_qbit_d;
    logic [WIDTH-1:0]   div_rem_d;
    logic [2*WIDTH-1:0] prod_fix_d;
    logic [WIDTH-1:0]   quo_fix_d, rem_fix_d;
    logic               w_unused;

    always_comb begin
        is_signed   = (funct == c_MULT) || (funct == c_DIV);
        mag1        = (is_signed && in1[WIDTH-1]) ? -in1 : in1;
        mag2        = (is_signed && in2[WIDTH-1]) ? -in2 : in2;

        mul_sum_d   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (opa_q[0] ? opb_q : {WIDTH{1'b0}})};
        mul_acc_d   = {mul_sum_d, acc_q[WIDTH-1:1]};

        // The partial remainder is always below the divisor, so WIDTH+1 bits hold the shift.
        div_shift_d = {acc_q[WIDTH-1:0], opa_q[WIDTH-1]};
        div_diff_d  = {1'b0, div_shift_d} - {2'b00, opb_q};
        div_qbit_d  = ~div_diff_d[WIDTH+1];
        div_rem_d   = div_qbit_d ? div_diff_d[WIDTH-1:0] : div_shift_d[WIDTH-1:0];
        w_unused    = div_diff_d[WIDTH];

        prod_fix_d  = neg_q ? -acc_q : acc_q;
        // A zero divisor yields an all-ones quotient that must not be sign-corrected.
        quo_fix_d   = (neg_q && !dz_q) ? -opa_q : opa_q;
        rem_fix_d   = rneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            is_div_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        case (funct)
                            c_MULT, c_MULTU: begin
                                opa_q    <= mag2;
                                opb_q    <= mag1;
                                acc_q    <= '0;
                                cnt_q    <= '0;
                                neg_q    <= is_signed && (in1[WIDTH-1] ^ in2[WIDTH-1]);
                                rneg_q   <= 1'b0;
                                dz_q     <= 1'b0;
                                is_div_q <= 1'b0;
                                busy_q   <= 1'b1;
                                state_q  <= S_MUL;
                            end
                            c_DIV, c_DIVU: begin
                                opa_q    <= mag1;
                                opb_q    <= mag2;
                                acc_q    <= '0;
                                cnt_q    <= '0;
                                neg_q    <= is_signed && (in1[WIDTH-1] ^ in2[WIDTH-1]);
                                rneg_q   <= is_signed && in1[WIDTH-1];
                                dz_q     <= (in2 == '0);
                                is_div_q <= 1'b1;
                                busy_q   <= 1'b1;
                                state_q  <= S_DIV;
                            end
                            c_MTHI:  hi_q <= in1;
                            c_MTLO:  lo_q <= in1;
                            default: ;
                        endcase
                    end
                end
                S_MUL, S_DIV: begin
                    if (flush) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        if (state_q == S_MUL) begin
                            acc_q <= mul_acc_d;
                            opa_q <= {1'b0, opa_q[WIDTH-1:1]};
                        end else begin
                            acc_q <= {{WIDTH{1'b0}}, div_rem_d};
                            opa_q <= {opa_q[WIDTH-2:0], div_qbit_d};
                        end
                        cnt_q <= cnt_q + c_CNT_ONE;
                        if (cnt_q == c_CNT_LAST) state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                    if (!flush) begin
                        done_q <= 1'b1;
                        if (is_div_q) begin
                            hi_q <= rem_fix_d;
                            lo_q <= quo_fix_d;
                        end else begin
                            hi_q <= prod_fix_d[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix_d[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign out  = (funct == c_MFHI) ? hi_q :
                  (funct == c_MFLO) ? lo_q : {WIDTH{1'b0}};

endmodule

`default_nettype wire
